load_store_unit: RTL and testbench

Initiator for the data port of the processor's dual-port `ram`. It takes one load/store request at a time from the pipeline and drives the RAM data-port signals (`wEn`, `d_address`, `d_write_data`, `d_read_data`). It supports byte, half and word accesses: sub-word stores are done as read-modify-write, and loads are returned sign- or zero-extended. The RAM is word-indexed, reads combinationally from `d_address`, and writes on the posedge of `clock` when `wEn`=1.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the RAM data
// port. Handles byte/half/word accesses, doing sub-word stores as
// read-modify-write and returning loads sign- or zero-extended.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. A response transfers on a rising edge where resp_valid
// and resp_ready are both 1. While resp_valid is 1, resp_rdata and resp_error
// hold steady. req_ready is 1 only in IDLE, so one request is in flight at a time.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  wEn,
  output logic [ADDR_WIDTH-1:0] d_address,
  output logic [DATA_WIDTH-1:0] d_write_data,
  input  logic [DATA_WIDTH-1:0] d_read_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_nxt;

  // Latched request fields (word address lives in d_address).
  logic [1:0]  l_lane;
  logic [1:0]  l_size;
  logic        l_signed;
  logic        l_write;
  logic [31:0] l_wdata;
  logic [31:0] old_word;

  logic        req_err;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign rd_word    = d_read_data[31:0];
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign wEn        = (state == WRITE);
  assign dbg_state  = state;

  // Classify the incoming request: illegal size, misalignment or out of range.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'd3)
      req_err = 1'b1;
    if (req_size == 2'd1 && req_addr[0])
      req_err = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0)
      req_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)
            state_nxt = RESP;
          else if (!req_write || req_size != 2'd2)
            state_nxt = READ;
          else
            state_nxt = WRITE;
        end
      end
      READ:    state_nxt = l_write ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Load lane select and extension from the word being read.
  always_comb begin
    rd_byte  = rd_word[{l_lane, 3'b000} +: 8];
    rd_half  = l_lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (l_size)
      2'd0:    load_val = {{24{l_signed & rd_byte[7]}}, rd_byte};
      2'd1:    load_val = {{16{l_signed & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Store word: the old word with only the addressed lane replaced.
  always_comb begin
    merged = old_word;
    case (l_size)
      2'd0:    merged[{l_lane, 3'b000} +: 8]     = l_wdata[7:0];
      2'd1:    merged[{l_lane[1], 4'b0000} +: 16] = l_wdata[15:0];
      default: merged = l_wdata;
    endcase
  end

  // Write data is only driven while the write enable is up.
  assign d_write_data = wEn ? DATA_WIDTH'(merged) : '0;

  // Request latch, old-word capture and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      l_lane     <= 2'b00;
      l_size     <= 2'b00;
      l_signed   <= 1'b0;
      l_write    <= 1'b0;
      l_wdata    <= 32'd0;
      old_word   <= 32'd0;
      d_address  <= '0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_lane     <= req_addr[1:0];
            l_size     <= req_size;
            l_signed   <= req_signed;
            l_write    <= req_write;
            l_wdata    <= req_wdata;
            d_address  <= req_addr[ADDR_WIDTH+1:2];
            resp_error <= req_err;
            resp_rdata <= 32'd0;
          end
        end
        READ: begin
          if (l_write)
            old_word <= rd_word;
          else
            resp_rdata <= load_val;
        end
        WRITE: begin
          resp_rdata <= 32'd0;
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives directed and random requests into the load/store
// unit over a behavioural RAM, and checks responses and RAM writes against a
// byte-addressed memory model.
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic          wEn;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_write_data;
  logic [DW-1:0] d_read_data;
  logic [1:0]    dbg_state;

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .wEn(wEn),
    .d_address(d_address), .d_write_data(d_write_data),
    .d_read_data(d_read_data), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: combinational read, posedge write.
  logic [31:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = 32'd0;
  assign d_read_data = ram[d_address];
  always @(posedge clock) if (wEn) ram[d_address] <= d_write_data;

  // Reference memory, byte addressed, default 0.
  logic [7:0] mbytes [int];
  function automatic logic [7:0] mb(input int a);
    return mbytes.exists(a) ? mbytes[a] : 8'h00;
  endfunction
  function automatic logic [31:0] mword(input int base);
    return {mb(base + 3), mb(base + 2), mb(base + 1), mb(base)};
  endfunction

  // Scoreboard
  logic [32:0] exp_q[$];   // {error, rdata}
  int          lat_q[$];
  int          acc_q[$];
  logic [47:0] wr_q[$];    // {word address, write word}
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // resp_ready driver: 0 = always ready, 1 = random, 2 = held low
  int rr_mode = 0;
  always @(posedge clock) begin
    #1;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = ($urandom_range(0, 3) != 0);
      default: resp_ready = 1'b0;
    endcase
  end

  // Response monitor
  logic        seen = 1'b0;
  logic [32:0] hold;
  always @(negedge clock) begin
    if (reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid), 64'(0));
      end else begin
        if (!seen) begin
          check("latency", 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
          seen = 1'b1;
          hold = {resp_error, resp_rdata};
        end else begin
          check("resp_stable", 64'({resp_error, resp_rdata}), 64'(hold));
        end
        if (resp_ready) begin
          check("resp", 64'({resp_error, resp_rdata}), 64'(exp_q.pop_front()));
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // RAM write monitor
  always @(negedge clock) begin
    if (reset) begin
      if (wEn) begin
        if (wr_q.size() == 0) begin
          check("wen_unexpected", 64'(wEn), 64'(0));
        end else begin
          logic [47:0] w;
          w = wr_q.pop_front();
          check("wr_addr", 64'(d_address), 64'(w[47:32]));
          check("wr_data", 64'(d_write_data), 64'(w[31:0]));
        end
      end else begin
        check("wdata_idle", 64'(d_write_data), 64'(0));
      end
    end
  end

  // Driver: issue one request, push its expected outcome from the model.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    int          nb;
    int          n;
    logic        err;
    logic [31:0] val;
    int          base;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err  = (sz == 2'd3) || ((int'(ad[1:0]) % nb) != 0) || (ad >= 32'h0004_0000);
    base = int'({ad[31:2], 2'b00});
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(req_ready), 64'(1));
      return;
    end
    if (err) begin
      exp_q.push_back({1'b1, 32'd0});
      lat_q.push_back(1);
    end else if (wr) begin
      for (int i = 0; i < nb; i++) mbytes[int'(ad) + i] = wd[8*i +: 8];
      wr_q.push_back({16'(base / 4), mword(base)});
      exp_q.push_back({1'b0, 32'd0});
      lat_q.push_back((nb == 4) ? 2 : 3);
    end else begin
      val = 32'd0;
      for (int i = 0; i < nb; i++) val[8*i +: 8] = mb(int'(ad) + i);
      if (sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
      exp_q.push_back({1'b0, val});
      lat_q.push_back(2);
    end
    acc_q.push_back(cyc + 1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Main sequence
  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rst_resp_error", 64'(resp_error), 64'(0));
    check("rst_wen", 64'(wEn), 64'(0));
    check("rst_d_address", 64'(d_address), 64'(0));
    check("rst_d_write_data", 64'(d_write_data), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(0));
    reset = 1'b1;

    // Directed accesses
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h10, 32'h00001234);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    // Error cases
    issue(1'b1, 2'd2, 1'b0, 32'h13, 32'h11111111);
    issue(1'b0, 2'd2, 1'b0, 32'h0004_0000, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h22222222);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    drain();
    check("ram_word4", 64'(ram[4]), 64'(mword(16)));

    // Backpressure: response held for 3 cycles, new requests ignored.
    rr_mode = 2;
    @(negedge clock);
    @(negedge clock);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    begin
      int n;
      n = 0;
      while (!resp_valid && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("bp_resp_valid", 64'(resp_valid), 64'(1));
      for (int k = 0; k < 3; k++) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h40;
        req_wdata = 32'hBADBAD00;
        check("bp_req_ready", 64'(req_ready), 64'(0));
        check("bp_valid_held", 64'(resp_valid), 64'(1));
        @(negedge clock);
      end
      req_valid = 1'b0;
      rr_mode   = 0;
    end
    drain();
    check("bp_no_write", 64'(ram[16]), 64'(mword(64)));

    // Reset in the middle of a word store to 0x20.
    @(negedge clock);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000055;
    @(posedge clock);
    #1;
    check("mid_write_wen", 64'(wEn), 64'(1));
    req_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("rstw_wen", 64'(wEn), 64'(0));
    check("rstw_resp_valid", 64'(resp_valid), 64'(0));
    check("rstw_resp_rdata", 64'(resp_rdata), 64'(0));
    check("rstw_resp_error", 64'(resp_error), 64'(0));
    check("rstw_d_address", 64'(d_address), 64'(0));
    check("rstw_d_write_data", 64'(d_write_data), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    check("rstw_ram_word8", 64'(ram[8]), 64'(mword(32)));
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h00000055);
    issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
    drain();

    // Random traffic with random backpressure.
    rr_mode = 1;
    for (int t = 0; t < 250; t++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'(($urandom_range(0, 2)));
      if ($urandom_range(0, 9) == 0) ad = $urandom;
      else ad = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    end
    rr_mode = 0;
    drain();
    repeat (3) @(negedge clock);
    check("wr_q_empty", 64'(wr_q.size()), 64'(0));
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
